// File: rtl/time_set_pkg.sv
// Shared types and defaults for the time-setting controller and its repeat engines.
package time_set_pkg;

    localparam int DEF_NUM_FIELDS   = 2;
    localparam int DEF_REPEAT_DELAY = 500;
    localparam int DEF_REPEAT_RATE  = 100;
    localparam int DEF_TIMEOUT      = 10000;
    localparam int DEF_BLINK_HALF   = 250;

    // RUN, or SET with the active field held in a separate index register.
    typedef enum logic {
        MODE_RUN = 1'b0,
        MODE_SET = 1'b1
    } mode_e;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_repeat.sv
// One-direction press/hold engine: a pulse on press, then auto-repeat after a delay.
module key_repeat
    import time_set_pkg::*;
#(
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    input  logic btn,
    input  logic other,
    output logic fire
);

    localparam int CW = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

    logic          act;
    logic          prev;
    logic          armed;
    logic          rep;
    logic [CW-1:0] cnt;
    logic          press;
    logic          due;

    // With both buttons down neither side is active, so releasing one
    // produces a fresh rising edge on the other.
    assign act   = btn & ~other;
    assign press = act & ~prev & ~clr;
    assign due   = act & armed & ~clr & tick & (cnt >= (rep ? RATE_LAST : DELAY_LAST));
    assign fire  = press | due;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b0;
            armed <= 1'b0;
            rep   <= 1'b0;
            cnt   <= '0;
        end else begin
            prev <= act;
            // A clear while held leaves prev high and armed low, so the
            // button must be released and pressed again to act.
            if (clr || !act) begin
                armed <= 1'b0;
                rep   <= 1'b0;
                cnt   <= '0;
            end else if (press) begin
                armed <= 1'b1;
                rep   <= 1'b0;
                cnt   <= tick ? CW'(1) : '0;
            end else if (armed && tick) begin
                if (due) begin
                    rep <= 1'b1;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Mode FSM walking the settable fields, with inc/dec pulse generation,
// display blink and an inactivity timeout back to run mode.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int NUM_FIELDS   = DEF_NUM_FIELDS,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  btn_mode,
    input  logic                  btn_add,
    input  logic                  btn_sub,
    output logic                  stop,
    output logic                  set_active,
    output logic [NUM_FIELDS-1:0] field_sel,
    output logic [NUM_FIELDS-1:0] inc,
    output logic [NUM_FIELDS-1:0] dec,
    output logic                  blink
);

    localparam int FW = cnt_width(NUM_FIELDS - 1);
    localparam int TW = cnt_width(TIMEOUT);
    localparam int BW = cnt_width(BLINK_HALF);
    localparam logic [FW-1:0]         TOP_FIELD = FW'(NUM_FIELDS - 1);
    localparam logic [NUM_FIELDS-1:0] TOP_HOT   = NUM_FIELDS'(1) << (NUM_FIELDS - 1);
    localparam logic [TW-1:0]         T_LAST    = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0]         B_LAST    = BW'(BLINK_HALF - 1);

    mode_e                 mode;
    logic [FW-1:0]         field;
    logic [TW-1:0]         tcnt;
    logic [BW-1:0]         bcnt;
    logic                  mode_q;
    logic                  in_set;
    logic                  mode_edge;
    logic                  activity;
    logic                  timeout_hit;
    logic                  rep_clr;
    logic                  fire_add;
    logic                  fire_sub;
    logic [NUM_FIELDS-1:0] field_hot;

    assign in_set    = (mode == MODE_SET);
    assign mode_edge = btn_mode & ~mode_q;
    // An add/sub rising edge implies its level is high, so levels cover edges.
    assign activity    = mode_edge | btn_add | btn_sub;
    assign timeout_hit = in_set & tick & ~activity & (tcnt == T_LAST);
    assign rep_clr     = ~in_set | mode_edge | timeout_hit;

    always_comb begin
        field_hot = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            field_hot[i] = (field == FW'(i));
        end
    end

    key_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_rep_add (
        .clk  (clk),
        .rst  (rst),
        .clr  (rep_clr),
        .tick (tick),
        .btn  (btn_add),
        .other(btn_sub),
        .fire (fire_add)
    );

    key_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_rep_sub (
        .clk  (clk),
        .rst  (rst),
        .clr  (rep_clr),
        .tick (tick),
        .btn  (btn_sub),
        .other(btn_add),
        .fire (fire_sub)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode       <= MODE_RUN;
            field      <= '0;
            tcnt       <= '0;
            bcnt       <= '0;
            mode_q     <= 1'b0;
            stop       <= 1'b0;
            set_active <= 1'b0;
            field_sel  <= '0;
            inc        <= '0;
            dec        <= '0;
            blink      <= 1'b1;
        end else begin
            mode_q <= btn_mode;
            inc    <= '0;
            dec    <= '0;
            if (!in_set) begin
                tcnt  <= '0;
                bcnt  <= '0;
                blink <= 1'b1;
                if (mode_edge) begin
                    mode       <= MODE_SET;
                    field      <= TOP_FIELD;
                    field_sel  <= TOP_HOT;
                    stop       <= 1'b1;
                    set_active <= 1'b1;
                    blink      <= 1'b0;
                end
            end else if (mode_edge || timeout_hit) begin
                // A mode edge outranks a coincident timeout.
                tcnt <= '0;
                bcnt <= '0;
                if (mode_edge && field != '0) begin
                    field     <= field - 1'b1;
                    field_sel <= field_sel >> 1;
                    blink     <= 1'b0;
                end else begin
                    mode       <= MODE_RUN;
                    field      <= '0;
                    field_sel  <= '0;
                    stop       <= 1'b0;
                    set_active <= 1'b0;
                    blink      <= 1'b1;
                end
            end else begin
                if (activity) begin
                    tcnt <= '0;
                end else if (tick) begin
                    tcnt <= tcnt + 1'b1;
                end
                if (fire_add || fire_sub) begin
                    inc   <= fire_add ? field_hot : '0;
                    dec   <= fire_sub ? field_hot : '0;
                    bcnt  <= '0;
                    blink <= 1'b1;
                end else if (tick) begin
                    if (bcnt == B_LAST) begin
                        bcnt  <= '0;
                        blink <= ~blink;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random stimulus against a rule-level model.
module tb_time_set_ctrl;

    localparam int NF = 3;
    localparam int RD = 4;
    localparam int RR = 2;
    localparam int TO = 20;
    localparam int BH = 3;
    localparam int W  = 3 * NF + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic          btn_mode;
    logic          btn_add;
    logic          btn_sub;
    logic          stop;
    logic          set_active;
    logic [NF-1:0] field_sel;
    logic [NF-1:0] inc;
    logic [NF-1:0] dec;
    logic          blink;

    time_set_ctrl #(
        .NUM_FIELDS  (NF),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR),
        .TIMEOUT     (TO),
        .BLINK_HALF  (BH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn_mode  (btn_mode),
        .btn_add   (btn_add),
        .btn_sub   (btn_sub),
        .stop      (stop),
        .set_active(set_active),
        .field_sel (field_sel),
        .inc       (inc),
        .dec       (dec),
        .blink     (blink)
    );

    initial forever #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    // Observation of DUT pulses per directed scenario.
    int          obs_pulses;
    int          obs_pos[$];
    int          call_idx;
    logic [NF-1:0] obs_inc_or;
    logic [NF-1:0] obs_dec_or;

    // Reference model state.
    bit m_set;
    int m_field;
    int m_idle;
    int m_bt;
    bit m_bbase;
    bit p_mode;
    bit m_pe[2];
    bit m_eng[2];
    int m_n[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Pulse rule: one on press, then whenever held ticks n reach RD, RD+RR, RD+2RR, ...
    function automatic bit engine(input int b, input bit e, input bit t);
        bit fire = 1'b0;
        if (!e) begin
            m_eng[b] = 1'b0;
        end else if (!m_pe[b]) begin
            m_eng[b] = 1'b1;
            m_n[b]   = t ? 1 : 0;
            fire     = 1'b1;
        end else if (m_eng[b] && t) begin
            m_n[b]++;
            fire = (m_n[b] >= RD) && (((m_n[b] - RD) % RR) == 0);
        end
        return fire;
    endfunction

    function automatic void model_step(input bit r, input bit m, input bit a, input bit s, input bit t);
        bit ea, es, mrise, act, tmo, pa, ps, o_blink;
        logic [NF-1:0] o_inc, o_dec, o_sel, hot;
        ea    = a & ~s;
        es    = s & ~a;
        mrise = m & ~p_mode;
        act   = mrise | a | s;
        o_inc = '0;
        o_dec = '0;
        if (r) begin
            m_set = 1'b0; m_field = 0; m_idle = 0; m_bt = 0; m_bbase = 1'b1;
            p_mode = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_pe[i] = 1'b0; m_eng[i] = 1'b0; m_n[i] = 0;
            end
        end else begin
            if (!m_set) begin
                m_eng[0] = 1'b0;
                m_eng[1] = 1'b0;
                if (mrise) begin
                    m_set = 1'b1; m_field = NF - 1; m_idle = 0; m_bt = 0; m_bbase = 1'b0;
                end
            end else begin
                tmo = t && !act && (m_idle + 1 == TO);
                if (mrise || tmo) begin
                    m_eng[0] = 1'b0;
                    m_eng[1] = 1'b0;
                    m_idle   = 0;
                    if (mrise && m_field > 0) begin
                        m_field--; m_bt = 0; m_bbase = 1'b0;
                    end else begin
                        m_set = 1'b0;
                    end
                end else begin
                    m_idle = act ? 0 : m_idle + (t ? 1 : 0);
                    pa  = engine(0, ea, t);
                    ps  = engine(1, es, t);
                    hot = NF'(1) << m_field;
                    if (pa || ps) begin
                        o_inc = pa ? hot : '0;
                        o_dec = ps ? hot : '0;
                        m_bt = 0; m_bbase = 1'b1;
                    end else if (t) begin
                        m_bt++;
                    end
                end
            end
            p_mode  = m;
            m_pe[0] = ea;
            m_pe[1] = es;
        end
        o_sel   = m_set ? (NF'(1) << m_field) : '0;
        o_blink = m_set ? (m_bbase ^ (((m_bt / BH) % 2) == 1)) : 1'b1;
        exp_q.push_back({m_set, m_set, o_sel, o_inc, o_dec, o_blink});
    endfunction

    function automatic logic [W-1:0] outs();
        return {stop, set_active, field_sel, inc, dec, blink};
    endfunction

    task automatic obs_clear();
        obs_pulses = 0;
        obs_pos.delete();
        call_idx   = 0;
        obs_inc_or = '0;
        obs_dec_or = '0;
    endtask

    task automatic cycle(input bit r, input bit m, input bit a, input bit s, input bit t);
        rst = r; btn_mode = m; btn_add = a; btn_sub = s; tick = t;
        model_step(r, m, a, s, t);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard: expected queue empty at %0t", $time);
        end else begin
            check("outs", 32'(outs()), 32'(exp_q.pop_front()));
        end
        if (inc != '0 || dec != '0) begin
            obs_pulses++;
            obs_pos.push_back(call_idx);
        end
        obs_inc_or |= inc;
        obs_dec_or |= dec;
        call_idx++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic mode_press();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    logic [NF-1:0] sel_seq[4] = '{3'b100, 3'b010, 3'b001, 3'b000};
    int            rep_pos[6] = '{0, 3, 5, 7, 9, 11};

    initial begin
        int found;
        bit ra, rs, rm, rr, rt;

        obs_clear();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_outs", 32'(outs()), 32'h001);
        idle(2);

        // Walk all modes.
        for (int i = 0; i < 4; i++) begin
            mode_press();
            check("mode_sel", 32'(field_sel), 32'(sel_seq[i]));
            check("mode_stop", 32'(stop), (i < 3) ? 32'd1 : 32'd0);
            idle(1);
        end

        // Single add press in SET(2).
        mode_press();
        idle(1);
        obs_clear();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(3);
        check("add_press_cnt", 32'(obs_pulses), 32'd1);
        check("add_press_inc", 32'(obs_inc_or), 32'b100);
        check("add_press_dec", 32'(obs_dec_or), 32'b000);

        // Hold sub 12 ticks in SET(1).
        mode_press();
        idle(1);
        obs_clear();
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        check("hold_sub_cnt", 32'(obs_pulses), 32'd6);
        check("hold_sub_dec", 32'(obs_dec_or), 32'b010);
        check("hold_sub_inc", 32'(obs_inc_or), 32'b000);
        for (int i = 0; i < obs_pos.size() && i < 6; i++)
            check("hold_sub_pos", 32'(obs_pos[i]), 32'(rep_pos[i]));

        // Both held in SET(0), then release sub.
        mode_press();
        idle(1);
        obs_clear();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("both_quiet", 32'(obs_pulses), 32'd0);
        obs_clear();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);
        check("release_sub_cnt", 32'(obs_pulses), 32'd1);
        check("release_sub_inc", 32'(obs_inc_or), 32'b001);
        check("release_sub_pos", (obs_pos.size() > 0) ? 32'(obs_pos[0]) : 32'hffff_ffff, 32'd0);

        // Back to RUN, then let SET(2) time out.
        mode_press();
        idle(1);
        mode_press();
        found = -1;
        for (int k = 1; k <= 2 * TO; k++) begin
            idle(1);
            if (!stop) begin
                found = k;
                break;
            end
        end
        check("timeout_ticks", 32'(found), 32'd20);
        check("timeout_sel", 32'(field_sel), 32'd0);
        check("timeout_blink", 32'(blink), 32'd1);

        // Reset while add is held.
        mode_press();
        idle(1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("rst_outs", 32'(outs()), 32'h001);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("rst_hold", 32'(outs()), 32'h001);
        idle(2);

        // Random traffic.
        ra = 1'b0;
        rs = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) ra = ~ra;
            if ($urandom_range(0, 7) == 0) rs = ~rs;
            rm = ($urandom_range(0, 24) == 0);
            rr = ($urandom_range(0, 399) == 0);
            rt = ($urandom_range(0, 3) != 0);
            cycle(rr, rm, ra, rs, rt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
